bus_rr_master: RTL and testbench

Parametrised multi-channel bus master. It arbitrates NUM_CH requester channels round-robin and issues one read or write at a time on a single addr/data/wen/ren/ready bus. The granted channel id is driven on valid. Next-generation bus front end: generalised address/data width and channel count, plus arbitration, ready handshake, per-channel completion and an optional timeout. Read data return is handled outside this block.

---
 rtl/bus_rr_master.sv | 255 +++++++++++++++++++++++++
 tb/tb_bus_rr_master.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_rr_master.sv
`default_nettype none
// ============================================================================
//  Module      : bus_rr_master
//  Description : Multi-channel bus master. NUM_CH requester channels are
//                arbitrated round-robin; the winner's read or write is issued
//                on a single addr/data/wen/ren bus and held until the target
//                returns ready. The winning channel then gets a one-cycle
//                ch_ack pulse. Read data return is handled outside this block.
//
//  Ports       : clk       - clock, all logic on the rising edge
//                reset     - synchronous, active-high reset
//                ch_req    - per-channel request, held until ch_ack
//                ch_wr     - per-channel direction (1 = write, 0 = read)
//                ch_addr   - packed per-channel address, ch k at [k*ADDR_W +: ADDR_W]
//                ch_wdata  - packed per-channel write data, same packing
//                ch_ack    - one-hot, one-cycle completion pulse
//                ch_err    - qualifies ch_ack: 1 = aborted by timeout
//                addr      - bus address
//                valid     - id of the channel owning the bus
//                data      - bus write data (0 on reads)
//                wen / ren - bus write / read strobes
//                ready     - target accepts the current strobe
//                busy      - high while a transfer is in BUS or ACK
//
//  Options     : `define BUS_RR_MASTER_TIMEOUT_EN enables the BUS-state
//                timeout (TIMEOUT_CYC cycles without ready aborts the
//                transfer with ch_err = 1). Without it ch_err is tied low and
//                BUS waits for ready indefinitely.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_rr_master #(
    parameter int NUM_CH      = 8,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 64,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         ch_req,
    input  logic [NUM_CH-1:0]         ch_wr,
    input  logic [NUM_CH*ADDR_W-1:0]  ch_addr,
    input  logic [NUM_CH*DATA_W-1:0]  ch_wdata,
    output logic [NUM_CH-1:0]         ch_ack,
    output logic                      ch_err,
    output logic [ADDR_W-1:0]         addr,
    output logic [$clog2(NUM_CH)-1:0] valid,
    output logic [DATA_W-1:0]         data,
    output logic                      wen,
    output logic                      ren,
    input  logic                      ready,
    output logic                      busy
);

    localparam int c_ID_W  = $clog2(NUM_CH);
    // One extra bit so rr_ptr + offset never overflows before the wrap.
    localparam int c_IDX_W = c_ID_W + 1;
    localparam logic [c_ID_W-1:0]  c_LAST_CH = c_ID_W'(NUM_CH - 1);
    localparam logic [c_IDX_W-1:0] c_NUM_CH  = c_IDX_W'(NUM_CH);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_BUS  = 2'd1;
    localparam logic [1:0] c_ST_ACK  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = c_ST_IDLE,
        ST_BUS  = c_ST_BUS,
        ST_ACK  = c_ST_ACK
    } state_t;

    // ------------------------------------------------------------------
    // Per-channel views of the packed address / write-data buses
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] w_ch_addr  [NUM_CH];
    logic [DATA_W-1:0] w_ch_wdata [NUM_CH];

    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
            assign w_ch_addr[k]  = ch_addr[k*ADDR_W +: ADDR_W];
            assign w_ch_wdata[k] = ch_wdata[k*DATA_W +: DATA_W];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t              r_state_q,  w_state_d;
    logic [ADDR_W-1:0]   r_addr_q,   w_addr_d;
    logic [c_ID_W-1:0]   r_valid_q,  w_valid_d;
    logic [DATA_W-1:0]   r_data_q,   w_data_d;
    logic                r_wen_q,    w_wen_d;
    logic                r_ren_q,    w_ren_d;
    logic [NUM_CH-1:0]   r_ch_ack_q, w_ch_ack_d;
    logic                r_busy_q,   w_busy_d;
    logic [c_ID_W-1:0]   r_rr_ptr_q, w_rr_ptr_d;

`ifdef BUS_RR_MASTER_TIMEOUT_EN
    // The counter holds the number of earlier ready-less BUS cycles, so the
    // current cycle is the TIMEOUT_CYC-th one when it equals TIMEOUT_CYC-1.
    localparam int c_CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYC - 1);

    logic [c_CNT_W-1:0]  r_tmo_cnt_q, w_tmo_cnt_d;
    logic                r_ch_err_q,  w_ch_err_d;
    logic                w_tmo_hit;

    assign w_tmo_hit = (r_tmo_cnt_q == c_CNT_LAST);
`endif

    // ------------------------------------------------------------------
    // Round-robin winner search: first set request at or above rr_ptr,
    // wrapping explicitly at NUM_CH (which need not be a power of two).
    // ------------------------------------------------------------------
    logic                w_found;
    logic [c_ID_W-1:0]   w_winner;
    logic [c_IDX_W-1:0]  w_idx;

    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_idx = {1'b0, r_rr_ptr_q} + c_IDX_W'(i);
            if (w_idx >= c_NUM_CH) begin
                w_idx = w_idx - c_NUM_CH;
            end
            if (!w_found && ch_req[w_idx[c_ID_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_idx[c_ID_W-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d  = r_state_q;
        w_addr_d   = r_addr_q;
        w_valid_d  = r_valid_q;
        w_data_d   = r_data_q;
        w_wen_d    = r_wen_q;
        w_ren_d    = r_ren_q;
        w_ch_ack_d = '0;
        w_rr_ptr_d = r_rr_ptr_q;
`ifdef BUS_RR_MASTER_TIMEOUT_EN
        w_tmo_cnt_d = r_tmo_cnt_q;
        w_ch_err_d  = 1'b0;
`endif

        case (r_state_q)
            ST_IDLE: begin
                w_wen_d = 1'b0;
                w_ren_d = 1'b0;
                if (w_found) begin
                    w_addr_d  = w_ch_addr[w_winner];
                    w_valid_d = w_winner;
                    w_data_d  = ch_wr[w_winner] ? w_ch_wdata[w_winner] : '0;
                    w_wen_d   = ch_wr[w_winner];
                    w_ren_d   = ~ch_wr[w_winner];
                    w_state_d = ST_BUS;
`ifdef BUS_RR_MASTER_TIMEOUT_EN
                    w_tmo_cnt_d = '0;
`endif
                end
            end

            ST_BUS: begin
                if (ready) begin
                    w_wen_d               = 1'b0;
                    w_ren_d               = 1'b0;
                    w_ch_ack_d[r_valid_q] = 1'b1;
                    w_state_d             = ST_ACK;
                end
`ifdef BUS_RR_MASTER_TIMEOUT_EN
                else if (w_tmo_hit) begin
                    w_wen_d               = 1'b0;
                    w_ren_d               = 1'b0;
                    w_ch_ack_d[r_valid_q] = 1'b1;
                    w_ch_err_d            = 1'b1;
                    w_state_d             = ST_ACK;
                end else begin
                    w_tmo_cnt_d = r_tmo_cnt_q + 1'b1;
                end
`endif
            end

            ST_ACK: begin
                // The pointer moves only once a transfer has finished, so a
                // waiting channel is passed over by at most NUM_CH-1 others.
                w_rr_ptr_d = (r_valid_q == c_LAST_CH) ? '0 : r_valid_q + 1'b1;
                w_state_d  = ST_IDLE;
            end

            default: begin
                w_wen_d   = 1'b0;
                w_ren_d   = 1'b0;
                w_state_d = ST_IDLE;
            end
        endcase

        w_busy_d = (w_state_d == ST_BUS) || (w_state_d == ST_ACK);
    end

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q   <= ST_IDLE;
            r_addr_q    <= '0;
            r_valid_q   <= '0;
            r_data_q    <= '0;
            r_wen_q     <= 1'b0;
            r_ren_q     <= 1'b0;
            r_ch_ack_q  <= '0;
            r_busy_q    <= 1'b0;
            r_rr_ptr_q  <= '0;
`ifdef BUS_RR_MASTER_TIMEOUT_EN
            r_tmo_cnt_q <= '0;
            r_ch_err_q  <= 1'b0;
`endif
        end else begin
            r_state_q   <= w_state_d;
            r_addr_q    <= w_addr_d;
            r_valid_q   <= w_valid_d;
            r_data_q    <= w_data_d;
            r_wen_q     <= w_wen_d;
            r_ren_q     <= w_ren_d;
            r_ch_ack_q  <= w_ch_ack_d;
            r_busy_q    <= w_busy_d;
            r_rr_ptr_q  <= w_rr_ptr_d;
`ifdef BUS_RR_MASTER_TIMEOUT_EN
            r_tmo_cnt_q <= w_tmo_cnt_d;
            r_ch_err_q  <= w_ch_err_d;
`endif
        end
    end

    assign addr   = r_addr_q;
    assign valid  = r_valid_q;
    assign data   = r_data_q;
    assign wen    = r_wen_q;
    assign ren    = r_ren_q;
    assign ch_ack = r_ch_ack_q;
    assign busy   = r_busy_q;

`ifdef BUS_RR_MASTER_TIMEOUT_EN
    assign ch_err = r_ch_err_q;
`else
    assign ch_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bus_rr_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_rr_master
//  Description : Self-checking bench for bus_rr_master. Directed steps cover
//                reset, single write, read with wait states, round-robin
//                order, reset mid-transfer, timeout behaviour and a 5-channel
//                instance; a randomized phase checks grants against a
//                queue-free round-robin reference computed with modulo
//                arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_rr_master;

    localparam int NCH = 8;
    localparam int AW  = 32;
    localparam int DW  = 64;
    localparam int N5  = 5;
    localparam int AW5 = 16;
    localparam int DW5 = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [NCH-1:0]    ch_req, ch_wr, ch_ack;
    logic [NCH*AW-1:0] ch_addr;
    logic [NCH*DW-1:0] ch_wdata;
    logic              ch_err, wen, ren, ready, busy;
    logic [AW-1:0]     addr;
    logic [2:0]        valid;
    logic [DW-1:0]     data;

    logic [N5-1:0]     ch_req5, ch_wr5, ch_ack5;
    logic [N5*AW5-1:0] ch_addr5;
    logic [N5*DW5-1:0] ch_wdata5;
    logic              ch_err5, wen5, ren5, ready5, busy5;
    logic [AW5-1:0]    addr5;
    logic [2:0]        valid5;
    logic [DW5-1:0]    data5;

    int n_tests = 0;
    int n_fail  = 0;
    int m_ptr   = 0;
    int exp_k   = 0;

    always #5 clk = ~clk;

    bus_rr_master #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(4)) dut (
        .clk(clk), .reset(reset),
        .ch_req(ch_req), .ch_wr(ch_wr), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
        .ch_ack(ch_ack), .ch_err(ch_err),
        .addr(addr), .valid(valid), .data(data), .wen(wen), .ren(ren),
        .ready(ready), .busy(busy)
    );

    bus_rr_master #(.NUM_CH(N5), .ADDR_W(AW5), .DATA_W(DW5), .TIMEOUT_CYC(4)) dut5 (
        .clk(clk), .reset(reset),
        .ch_req(ch_req5), .ch_wr(ch_wr5), .ch_addr(ch_addr5), .ch_wdata(ch_wdata5),
        .ch_ack(ch_ack5), .ch_err(ch_err5),
        .addr(addr5), .valid(valid5), .data(data5), .wen(wen5), .ren(ren5),
        .ready(ready5), .busy(busy5)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int k, input logic wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        ch_req[k]            = 1'b1;
        ch_wr[k]             = wr;
        ch_addr[k*AW +: AW]  = a;
        ch_wdata[k*DW +: DW] = d;
    endtask

    // Reference round-robin: first pending channel at or after ptr, modulo NCH.
    function automatic int pick(input logic [NCH-1:0] p, input int ptr);
        for (int d = 0; d < NCH; d++) begin
            if (p[(ptr + d) % NCH]) return (ptr + d) % NCH;
        end
        return 0;
    endfunction

    // Bus contents expected while channel k owns the bus.
    task automatic chk_bus(input string tag, input int k);
        logic [DW-1:0] exp_data;
        exp_data = ch_wr[k] ? ch_wdata[k*DW +: DW] : '0;
        chk({tag, " wen"},   wen,   ch_wr[k]);
        chk({tag, " ren"},   ren,   !ch_wr[k]);
        chk({tag, " valid"}, valid, k);
        chk({tag, " addr"},  addr,  ch_addr[k*AW +: AW]);
        chk({tag, " data"},  data,  exp_data);
        chk({tag, " noack"}, ch_ack, 0);
        chk({tag, " busy"},  busy,  1);
    endtask

    // Called with the DUT in IDLE and ch_req already driven; expects channel
    // k to win, holds ready low for 'waits' BUS cycles, then completes.
    task automatic transfer(input string tag, input int k, input int waits,
                            input logic rdy_idle);
        logic [NCH-1:0] exp_ack;
        ready = rdy_idle;
        tick();
        for (int w = 0; w <= waits; w++) begin
            chk_bus(tag, k);
            ready = (w == waits);
            tick();
        end
        exp_ack    = '0;
        exp_ack[k] = 1'b1;
        chk({tag, " ack"},      ch_ack, exp_ack);
        chk({tag, " err"},      ch_err, 0);
        chk({tag, " ack wen"},  wen,    0);
        chk({tag, " ack ren"},  ren,    0);
        chk({tag, " ack busy"}, busy,   1);
        ch_req[k] = 1'b0;
        ready     = 1'($urandom_range(0, 1));
        tick();
        chk({tag, " idle ack"},  ch_ack, 0);
        chk({tag, " idle busy"}, busy,   0);
        chk({tag, " idle wen"},  wen | ren, 0);
        ready = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        ch_req    = '0;  ch_wr    = '0;  ch_addr  = '0;  ch_wdata  = '0;  ready  = 1'b0;
        ch_req5   = '0;  ch_wr5   = '0;  ch_addr5 = '0;  ch_wdata5 = '0;  ready5 = 1'b0;

        // ---- reset values ----
        tick();
        tick();
        chk("rst ch_ack", ch_ack, 0);
        chk("rst ch_err", ch_err, 0);
        chk("rst addr",   addr,   0);
        chk("rst valid",  valid,  0);
        chk("rst data",   data,   0);
        chk("rst wen",    wen,    0);
        chk("rst ren",    ren,    0);
        chk("rst busy",   busy,   0);
        chk("rst5 busy",  busy5,  0);
        reset = 1'b0;

        // ---- single write, ready held high ----
        set_req(3, 1'b1, 32'h1000_0040, 64'hDEAD_BEEF_0123_4567);
        transfer("wr3", 3, 0, 1'b1);

        // ---- read with four wait states (rr_ptr now 4, ch0 only) ----
        set_req(0, 1'b0, 32'h0000_0020, 64'hFFFF_FFFF_FFFF_FFFF);
        transfer("rd0", 0, 4, 1'b0);

        // ---- round-robin with every channel requesting ----
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 0; c < NCH; c++)
            set_req(c, 1'(c & 1), 32'h4000 + 32'(c * 4), {32'hA5A5_0000, 32'(c)});
        for (int i = 0; i <= NCH; i++) begin
            transfer($sformatf("rr%0d", i), i % NCH, 0, 1'b1);
            set_req(i % NCH, 1'((i % NCH) & 1), 32'h4000 + 32'((i % NCH) * 4),
                    {32'hA5A5_0000, 32'(i % NCH)});
        end
        ch_req = '0;

        // ---- rr_ptr = 5 with only ch 2 and 6 pending ----
        set_req(4, 1'b1, 32'h44, 64'h4444);
        transfer("p4", 4, 0, 1'b1);
        set_req(2, 1'b0, 32'h22, 64'h2222);
        set_req(6, 1'b1, 32'h66, 64'h6666);
        transfer("p6", 6, 1, 1'b0);
        transfer("p2", 2, 0, 1'b1);

        // ---- reset during BUS: aborts, no ack, rr_ptr back to 0 ----
        set_req(5, 1'b0, 32'h55, 64'h5555);
        transfer("p5", 5, 0, 1'b1);
        set_req(7, 1'b1, 32'h77, 64'h7777);
        ready = 1'b0;
        tick();
        chk_bus("mid", 7);
        reset = 1'b1;
        tick();
        chk("mid rst wen",  wen,    0);
        chk("mid rst ren",  ren,    0);
        chk("mid rst ack",  ch_ack, 0);
        chk("mid rst busy", busy,   0);
        ch_req[7] = 1'b0;
        reset     = 1'b0;
        tick();
        chk("mid post ack", ch_ack, 0);
        set_req(1, 1'b0, 32'h11, 64'h1111);
        set_req(7, 1'b1, 32'h77, 64'h7777);
        transfer("post1", 1, 0, 1'b1);
        transfer("post7", 7, 0, 1'b1);

        // ---- ready never asserted ----
        set_req(2, 1'b1, 32'h2200, 64'h0BAD_CAFE);
        ready = 1'b0;
        tick();
`ifdef BUS_RR_MASTER_TIMEOUT_EN
        for (int w = 0; w < 4; w++) begin
            chk_bus($sformatf("tmo%0d", w), 2);
            tick();
        end
        chk("tmo ack",  ch_ack, 8'b0000_0100);
        chk("tmo err",  ch_err, 1);
        chk("tmo wen",  wen,    0);
        ch_req[2] = 1'b0;
        tick();
        chk("tmo idle ack",  ch_ack, 0);
        chk("tmo idle busy", busy,   0);
`else
        for (int w = 0; w < 100; w++) begin
            chk("hold wen", wen,    1);
            chk("hold ack", ch_ack, 0);
            tick();
        end
        ready = 1'b1;
        tick();
        chk("hold done ack", ch_ack, 8'b0000_0100);
        chk("hold done err", ch_err, 0);
        ch_req[2] = 1'b0;
        ready     = 1'b0;
        tick();
`endif

        // ---- 5-channel instance: wrap from ch 4 back to ch 0 ----
        ready5       = 1'b1;
        ch_req5[4]   = 1'b1;
        ch_wr5[4]    = 1'b1;
        ch_addr5[4*AW5 +: AW5]  = 16'h0444;
        ch_wdata5[4*DW5 +: DW5] = 16'hBEEF;
        tick();
        chk("n5 valid4", valid5, 4);
        chk("n5 wen4",   wen5,   1);
        chk("n5 data4",  data5,  16'hBEEF);
        tick();
        chk("n5 ack4",   ch_ack5, 5'b10000);
        ch_req5[4] = 1'b0;
        tick();
        ch_req5[0] = 1'b1;
        ch_req5[1] = 1'b1;
        ch_addr5[0 +: AW5]   = 16'h0100;
        ch_addr5[AW5 +: AW5] = 16'h0101;
        tick();
        chk("n5 valid0", valid5, 0);
        chk("n5 ren0",   ren5,   1);
        chk("n5 addr0",  addr5,  16'h0100);
        tick();
        chk("n5 ack0",   ch_ack5, 5'b00001);
        ch_req5[0] = 1'b0;
        tick();
        tick();
        chk("n5 valid1", valid5, 1);
        tick();
        chk("n5 ack1",   ch_ack5, 5'b00010);
        ch_req5[1] = 1'b0;
        ready5     = 1'b0;
        tick();

        // ---- randomized traffic against the reference arbiter ----
        reset = 1'b1;
        ch_req = '0;
        tick();
        reset = 1'b0;
        m_ptr = 0;
        for (int t = 0; t < 150; t++) begin
            for (int c = 0; c < NCH; c++) begin
                if (!ch_req[c] && $urandom_range(0, 2) == 0)
                    set_req(c, 1'($urandom_range(0, 1)), $urandom, {$urandom, $urandom});
            end
            if (ch_req == '0)
                set_req(int'($urandom_range(0, NCH - 1)), 1'b0, $urandom, {$urandom, $urandom});
            exp_k = pick(ch_req, m_ptr);
            transfer($sformatf("rnd%0d", t), exp_k, int'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)));
            m_ptr = (exp_k + 1) % NCH;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
